// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB grant scheduler.
// Requester index order is ALU units, then MULT units, then LOAD units.
package cdb_arbiter_pkg;

  localparam int unsigned NUM_FU_ALU  = 4;
  localparam int unsigned NUM_FU_MULT = 2;
  localparam int unsigned NUM_FU_LOAD = 2;

  localparam int unsigned NUM_REQ_DEF   = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
  localparam int unsigned NUM_LANE_DEF  = 4;
  localparam int unsigned AGE_LIMIT_DEF = 3;
  localparam int unsigned AGE_WIDTH_DEF = $clog2(AGE_LIMIT_DEF + 1);

  // Requester index map
  localparam int unsigned ALU_BASE  = 0;
  localparam int unsigned MULT_BASE = NUM_FU_ALU;
  localparam int unsigned LOAD_BASE = NUM_FU_ALU + NUM_FU_MULT;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant bundle between the functional units and the CDB arbiter.
//   req           FU -> arb  finished result pending, one bit per requester
//   lane_enable   FU -> arb  lane usable this cycle
//   squash        FU -> arb  branch-recovery flush
//   gnt           arb -> FU  requester wins a lane this cycle
//   gnt_bus       arb -> FU  one-hot requester select per lane
//   lane_valid    arb -> FU  lane carries a grant
//   starve_active arb -> FU  a grant came from the starvation pass
//   age_debug     arb -> FU  current age counters
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned NUM_LANE  = NUM_LANE_DEF,
  parameter int unsigned AGE_WIDTH = AGE_WIDTH_DEF
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_LANE-1:0]                lane_enable;
  logic                               squash;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_LANE-1:0][NUM_REQ-1:0]   gnt_bus;
  logic [NUM_LANE-1:0]                lane_valid;
  logic                               starve_active;
  logic [NUM_REQ-1:0][AGE_WIDTH-1:0]  age_debug;

  modport master (
    output req, lane_enable, squash,
    input  gnt, gnt_bus, lane_valid, starve_active, age_debug
  );

  modport slave (
    input  req, lane_enable, squash,
    output gnt, gnt_bus, lane_valid, starve_active, age_debug
  );
endinterface

// File: rtl/cdb_lane_alloc.sv
// Combinational lane allocator.
// Walks the high-priority vector in ascending index, then the low-priority
// vector in ascending index, handing each set requester the lowest enabled
// lane still free. Requesters left over when lanes run out get nothing.
//   i_req_hi       first-pass requesters
//   i_req_lo       second-pass requesters (disjoint from i_req_hi)
//   i_lane_enable  usable lanes
//   o_gnt_bus      one-hot requester select per lane
module cdb_lane_alloc #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned NUM_LANE = 4
) (
  input  logic [NUM_REQ-1:0]               i_req_hi,
  input  logic [NUM_REQ-1:0]               i_req_lo,
  input  logic [NUM_LANE-1:0]              i_lane_enable,
  output logic [NUM_LANE-1:0][NUM_REQ-1:0] o_gnt_bus
);

  always_comb begin
    logic [NUM_LANE-1:0] w_free;
    logic                w_done;
    o_gnt_bus = '0;
    w_free    = i_lane_enable;
    w_done    = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        w_done = 1'b0;
        if ((p == 0) ? i_req_hi[r] : i_req_lo[r]) begin
          for (int unsigned l = 0; l < NUM_LANE; l++) begin
            if (!w_done && w_free[l]) begin
              o_gnt_bus[l][r] = 1'b1;
              w_free[l]       = 1'b0;
              w_done          = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB grant scheduler: fixed priority (lowest index wins) with per-requester
// age counters that promote a requester denied AGE_LIMIT consecutive cycles
// ahead of the base policy.
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous reset, active low
//   bus      cdb_arbiter_if slave side (requests in, grants out)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned NUM_LANE  = NUM_LANE_DEF,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF,
  parameter int unsigned AGE_WIDTH = $clog2(AGE_LIMIT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0][AGE_WIDTH-1:0] r_age;
  logic [NUM_REQ-1:0]                w_starving;
  logic [NUM_REQ-1:0]                w_pri_hi;
  logic [NUM_REQ-1:0]                w_pri_lo;
  logic [NUM_REQ-1:0]                w_gnt;
  logic [NUM_LANE-1:0]               w_lane_valid;
  logic [NUM_LANE-1:0][NUM_REQ-1:0]  w_bus;
  logic                              w_live;

  always_comb begin
    w_starving = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      w_starving[i] = bus.req[i] && (r_age[i] == AGE_WIDTH'(AGE_LIMIT));
  end

  // Reset and squash both suppress grants by emptying the request vectors,
  // so every output collapses to zero through the allocator.
  assign w_live   = i_rst_n && !bus.squash;
  assign w_pri_hi = w_live ? w_starving : '0;
  assign w_pri_lo = w_live ? (bus.req & ~w_starving) : '0;

  cdb_lane_alloc #(
    .NUM_REQ  (NUM_REQ),
    .NUM_LANE (NUM_LANE)
  ) u_alloc (
    .i_req_hi      (w_pri_hi),
    .i_req_lo      (w_pri_lo),
    .i_lane_enable (bus.lane_enable),
    .o_gnt_bus     (w_bus)
  );

  always_comb begin
    w_gnt        = '0;
    w_lane_valid = '0;
    for (int unsigned l = 0; l < NUM_LANE; l++) begin
      w_gnt           = w_gnt | w_bus[l];
      w_lane_valid[l] = |w_bus[l];
    end
  end

  assign bus.gnt           = w_gnt;
  assign bus.gnt_bus       = w_bus;
  assign bus.lane_valid    = w_lane_valid;
  assign bus.starve_active = |(w_gnt & w_pri_hi);
  assign bus.age_debug     = r_age;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_age <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.squash || w_gnt[i] || !bus.req[i])
          r_age[i] <= '0;
        else if (r_age[i] != AGE_WIDTH'(AGE_LIMIT))
          r_age[i] <= r_age[i] + AGE_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sequential grant scheduler that decides which functional-unit completions (ALU, MULT, LOAD result holders) drive the `N CDB lanes each cycle.
- Base policy is fixed priority: lowest requester index wins.
- Per-requester age counters promote any requester denied for AGE_LIMIT consecutive cycles ahead of the base policy, so no unit starves.
- Outputs feed the CDB lane muxes and the per-unit accept/hold signals.

Parameters:
- NUM_REQ, `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD: number of requesters. Index order is ALU, then MULT, then LOAD.
- NUM_LANE, `N: number of CDB lanes.
- AGE_LIMIT, 3: consecutive denied cycles after which a requester is starving.
- AGE_WIDTH, $clog2(AGE_LIMIT+1): width of each age counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0).
- req  input  NUM_REQ  requester i holds a finished result. Must stay high until granted; may drop only on squash.
- lane_enable  input  NUM_LANE  lane usable this cycle; disabled lanes carry nothing.
- squash  input  1  branch-recovery flush. No grants this cycle; all ages cleared.
- gnt  output  NUM_REQ  requester i wins a lane this cycle.
- gnt_bus  output  NUM_LANE x NUM_REQ  one-hot select per lane (all zero when the lane is idle).
- lane_valid  output  NUM_LANE  lane carries a grant.
- starve_active  output  1  at least one grant this cycle came from the starvation pass.
- age_debug  output  NUM_REQ x AGE_WIDTH  current age counters.

Behaviour:
- Reset asserted: age[i]=0 immediately. gnt, gnt_bus, lane_valid and starve_active forced to 0 combinationally for as long as reset=0.
- Latency: grants are combinational from req, lane_enable, squash and the registered ages. Grant and data transfer happen in the same cycle as req.
- Grant capacity: G = popcount(lane_enable). At most G grants per cycle.
- Pass 1 (starvation): requesters with req[i] && age[i]==AGE_LIMIT, lowest index first, up to G.
- Pass 2 (fixed priority): remaining lanes go to other requesters with req[i], lowest index first.
- Lane assignment: grants are ordered pass-1 ascending, then pass-2 ascending. The k-th grant goes to the k-th enabled lane (ascending lane index).
- Invariant: each requester appears on at most one lane; gnt == OR over lanes of gnt_bus.
- Age update (rising edge), per requester i:
  - squash: age=0.
  - else if gnt[i] or !req[i]: age=0.
  - else: age=min(age+1, AGE_LIMIT), saturating.
- Boundary cases:
  - More starving requesters than G: lowest indices win. Losers stay at AGE_LIMIT and win in later cycles, so the wait bound is AGE_LIMIT + ceil(NUM_REQ/G) cycles.
  - lane_enable == 0: no grants; pending ages still increment.
  - squash together with req: no grants; ages 0 next cycle. Requester state after squash is the FU's responsibility.
  - req dropped without a grant (squash only): age clears.
  - Reset asserted mid-operation: outputs 0 at once; ages 0 on release; the first post-reset cycle uses pure fixed priority.
- starve_active = 1 iff pass 1 granted at least one requester.

Decomposition:
- Shared package (sys_defs): NUM_REQ-derived width constants. Requester index map localparams: ALU_BASE=0, MULT_BASE=`NUM_FU_ALU, LOAD_BASE=`NUM_FU_ALU+`NUM_FU_MULT.
- One sub-module, cdb_lane_alloc (purely combinational). Inputs: two priority request vectors and lane_enable. Output: gnt_bus.
- cdb_arbiter itself holds the age registers, the pass logic, and the squash and reset gating.

Test Plan (NUM_REQ=8, NUM_LANE=4, AGE_LIMIT=3):
- Reset release, lane_enable=4'hF, req=8'hFF -> gnt=8'h0F; gnt_bus[0..3]=bits 0..3; lane_valid=4'hF; ages of 4..7 = 1 next cycle.
- lane_enable=4'b0101, req=8'h07, ages 0 -> gnt=8'h03; gnt_bus[0]=8'h01, gnt_bus[2]=8'h02, lanes 1 and 3 zero; lane_valid=4'b0101; age[2]=1 next cycle.
- lane_enable=4'b0001, req=8'h81 held:
  - Cycles 0-2: gnt=8'h01; age[7] goes 1, 2, 3.
  - Cycle 3: gnt=8'h80, starve_active=1; age[7] then 0, age[0] then 1.
  - Cycle 4: gnt=8'h01.
- lane_enable=4'b0001, req=8'hC1 held: ages of 6 and 7 both hit 3 at cycle 3 -> cycle 3 grants 6, cycle 4 grants 7 (age 3 still), cycle 5 grants 0.
- age[5]=2, req=8'h20, squash=1 -> gnt=0 and lane_valid=0 that cycle; age[5]=0 next cycle; squash=0 next cycle -> gnt=8'h20.
- Ages nonzero, drive reset=0 mid-cycle -> all outputs 0 before the next edge. Release with req=8'hF0, lane_enable=4'b0011 -> gnt=8'h30; age_debug shows only ages 6 and 7 = 1 next cycle.
